// File: rtl/iq_avg_pkg.sv
// Shared types and constants for the IQ accumulate-and-dump averager sequencer.
package iq_avg_pkg;

    // Default maximum log2 of frames per average.
    localparam int unsigned AVG_LOG2_MAX_DEF = 10;

    // Sequencer state encoding, also exported in the status word.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACCUM    = 2'd2,
        ST_DONE     = 2'd3
    } seq_state_t;

    // Status word bit positions.
    localparam int unsigned STAT_BUSY_BIT     = 31;
    localparam int unsigned STAT_DONE_BIT     = 30;
    localparam int unsigned STAT_OVF_BIT      = 29;
    localparam int unsigned STAT_TMO_BIT      = 28;
    localparam int unsigned STAT_STATE_LO_BIT = 26;
    localparam int unsigned STAT_STATE_W      = 2;

endpackage

// File: rtl/iq_avg_frame_counter.sv
// Loadable frame counter with terminal-count compare against 2^n.
// tc is asserted while the count equals 2^n_log2, i.e. the average is complete.
module iq_avg_frame_counter
    import iq_avg_pkg::*;
#(
    parameter int unsigned AVG_LOG2_MAX = AVG_LOG2_MAX_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic                               load,
    input  logic                               inc,
    input  logic [$clog2(AVG_LOG2_MAX+1)-1:0]  n_log2,
    output logic                               tc
);

    // One extra bit so that 2^AVG_LOG2_MAX itself is representable.
    localparam int unsigned CW = AVG_LOG2_MAX + 1;

    logic [CW-1:0] count;

    // Frame count: clear wins over load, load (to 1) wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(1);
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == (CW'(1) << n_log2));

endmodule

// File: rtl/iq_avg_seq_ctrl.sv
// Sequencer for the IQ accumulate-and-dump averager.
// Drives acc_en / acc_clr / dump, counts frames and completed averages,
// flags dump overruns and packs the 32-bit status word.
// Optional macro IQ_AVG_TIMEOUT_EN builds a no-SOF watchdog (status[28]).
module iq_avg_seq_ctrl
    import iq_avg_pkg::*;
#(
    parameter int unsigned AVG_LOG2_MAX = AVG_LOG2_MAX_DEF,
    parameter int unsigned DUMP_CNT_W   = 16,
    parameter int unsigned TIMEOUT_CYC  = 1048576
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic                  ctrl_start,
    input  logic                  ctrl_abort,
    input  logic [4:0]            cfg_log2_navg,
    input  logic [DUMP_CNT_W-1:0] cfg_ndumps,
    input  logic                  sample_valid,
    input  logic                  frame_sof,
    input  logic                  snap_ready,
    output logic                  acc_en,
    output logic                  acc_clr,
    output logic                  dump,
    output logic [31:0]           status
);

    localparam int unsigned NW = $clog2(AVG_LOG2_MAX + 1);

    // Elaboration-time sanity checks on the configuration.
    if (DUMP_CNT_W > STAT_STATE_LO_BIT) begin : g_bad_dump_cnt_w
        $error("DUMP_CNT_W must not overlap the status flag field");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    seq_state_t            state;
    logic                  start_q;
    logic [NW-1:0]         n_lat;
    logic [DUMP_CNT_W-1:0] ndumps_lat;
    logic [DUMP_CNT_W-1:0] dump_cnt;
    logic                  ovf;
    logic                  tmo;

    logic                  start_pulse;
    logic                  qsof;
    logic                  busy;
    logic                  finish;
    logic                  tmo_hit;
    logic [DUMP_CNT_W-1:0] dump_cnt_inc;
    logic [NW-1:0]         n_clamped;

    logic                  fc_clr;
    logic                  fc_load;
    logic                  fc_inc;
    logic                  fc_tc;

    assign start_pulse  = ctrl_start & ~start_q;
    assign qsof         = sample_valid & frame_sof;
    assign busy         = (state == ST_WAIT_SOF) || (state == ST_ACCUM);
    assign dump_cnt_inc = dump_cnt + DUMP_CNT_W'(1);
    // The run ends on the dump that brings the count up to cfg_ndumps; 0 runs forever.
    assign finish       = (ndumps_lat != '0) && (dump_cnt_inc == ndumps_lat);
    assign n_clamped    = (cfg_log2_navg > 5'(AVG_LOG2_MAX)) ? NW'(AVG_LOG2_MAX)
                                                             : cfg_log2_navg[NW-1:0];

    function automatic logic [31:0] pack_status(
        input seq_state_t            s,
        input logic                  ovf_bit,
        input logic                  tmo_bit,
        input logic [DUMP_CNT_W-1:0] cnt
    );
        logic [31:0] w;
        w = '0;
        w[STAT_BUSY_BIT] = (s == ST_WAIT_SOF) || (s == ST_ACCUM);
        w[STAT_DONE_BIT] = (s == ST_DONE);
        w[STAT_OVF_BIT]  = ovf_bit;
        w[STAT_TMO_BIT]  = tmo_bit;
        w[STAT_STATE_LO_BIT +: STAT_STATE_W] = s;
        w[DUMP_CNT_W-1:0] = cnt;
        return w;
    endfunction

`ifdef IQ_AVG_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;

    // Watchdog: counts busy cycles since the last qualified SOF.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            tmo_cnt <= '0;
        end else if (!busy || qsof || ctrl_abort) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_hit = busy && !qsof && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Frame counter control mirrors the FSM decisions made this cycle.
    always_comb begin
        fc_clr  = 1'b0;
        fc_load = 1'b0;
        fc_inc  = 1'b0;
        if (!ctrl_abort && !tmo_hit) begin
            unique case (state)
                ST_IDLE:     fc_clr  = start_pulse;
                ST_WAIT_SOF: fc_load = qsof;
                ST_ACCUM: begin
                    if (qsof) begin
                        if (fc_tc) begin
                            fc_load = ~finish;
                        end else begin
                            fc_inc = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    iq_avg_frame_counter #(
        .AVG_LOG2_MAX (AVG_LOG2_MAX)
    ) u_frame_counter (
        .clk    (user_clk),
        .rst_n  (user_rst_n),
        .clr    (fc_clr),
        .load   (fc_load),
        .inc    (fc_inc),
        .n_log2 (n_lat),
        .tc     (fc_tc)
    );

    // Sequencer FSM with registered strobes, counters, sticky flags and status.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state      <= ST_IDLE;
            start_q    <= 1'b0;
            n_lat      <= '0;
            ndumps_lat <= '0;
            dump_cnt   <= '0;
            ovf        <= 1'b0;
            tmo        <= 1'b0;
            acc_en     <= 1'b0;
            acc_clr    <= 1'b0;
            dump       <= 1'b0;
            status     <= '0;
        end else begin
            start_q <= ctrl_start;
            acc_en  <= 1'b0;
            acc_clr <= 1'b0;
            dump    <= 1'b0;
            status  <= pack_status(state, ovf, tmo, dump_cnt);
            if (ctrl_abort) begin
                state <= ST_IDLE;
            end else if (tmo_hit) begin
                state <= ST_IDLE;
                tmo   <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_pulse) begin
                            n_lat      <= n_clamped;
                            ndumps_lat <= cfg_ndumps;
                            dump_cnt   <= '0;
                            ovf        <= 1'b0;
                            tmo        <= 1'b0;
                            state      <= ST_WAIT_SOF;
                        end
                    end
                    ST_WAIT_SOF: begin
                        if (qsof) begin
                            acc_en  <= 1'b1;
                            acc_clr <= 1'b1;
                            state   <= ST_ACCUM;
                        end
                    end
                    ST_ACCUM: begin
                        if (sample_valid) begin
                            acc_en <= 1'b1;
                            if (frame_sof && fc_tc) begin
                                // Dump goes out even when the snapshot buffer is busy.
                                dump     <= 1'b1;
                                dump_cnt <= dump_cnt_inc;
                                if (!snap_ready) begin
                                    ovf <= 1'b1;
                                end
                                if (finish) begin
                                    acc_en <= 1'b0;
                                    state  <= ST_DONE;
                                end else begin
                                    acc_clr <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        if (!ctrl_start) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iq_avg_seq_ctrl.sv
// Directed self-checking bench for iq_avg_seq_ctrl (default build).
module tb_iq_avg_seq_ctrl;

    localparam int unsigned DW = 16;

    logic          user_clk;
    logic          user_rst_n;
    logic          ctrl_start;
    logic          ctrl_abort;
    logic [4:0]    cfg_log2_navg;
    logic [DW-1:0] cfg_ndumps;
    logic          sample_valid;
    logic          frame_sof;
    logic          snap_ready;
    logic          acc_en;
    logic          acc_clr;
    logic          dump;
    logic [31:0]   status;

    int n_assert;
    int n_fail;
    int dump_total;

    iq_avg_seq_ctrl #(
        .AVG_LOG2_MAX (10),
        .DUMP_CNT_W   (DW),
        .TIMEOUT_CYC  (1048576)
    ) dut (
        .user_clk      (user_clk),
        .user_rst_n    (user_rst_n),
        .ctrl_start    (ctrl_start),
        .ctrl_abort    (ctrl_abort),
        .cfg_log2_navg (cfg_log2_navg),
        .cfg_ndumps    (cfg_ndumps),
        .sample_valid  (sample_valid),
        .frame_sof     (frame_sof),
        .snap_ready    (snap_ready),
        .acc_en        (acc_en),
        .acc_clr       (acc_clr),
        .dump          (dump),
        .status        (status)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the edge; tally dump pulses.
    task automatic cyc();
        @(posedge user_clk);
        #1;
        if (dump === 1'b1) dump_total++;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        frame_sof    = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    // One frame of len valid samples; returns the outputs seen for its SOF sample.
    task automatic frame(input int len, input logic snap,
                         output logic d, output logic c, output logic e);
        d = 1'b0; c = 1'b0; e = 1'b0;
        for (int i = 0; i < len; i++) begin
            sample_valid = 1'b1;
            frame_sof    = (i == 0);
            snap_ready   = snap;
            cyc();
            if (i == 0) begin
                d = dump; c = acc_clr; e = acc_en;
            end
        end
        sample_valid = 1'b0;
        frame_sof    = 1'b0;
        snap_ready   = 1'b1;
    endtask

    initial begin
        logic d, c, e;
        int   base;
        n_assert      = 0;
        n_fail        = 0;
        dump_total    = 0;
        user_rst_n    = 1'b0;
        ctrl_start    = 1'b0;
        ctrl_abort    = 1'b0;
        cfg_log2_navg = 5'd0;
        cfg_ndumps    = '0;
        sample_valid  = 1'b0;
        frame_sof     = 1'b0;
        snap_ready    = 1'b1;

        // Reset state
        #12;
        chk("rst_acc_en", {31'd0, acc_en}, 32'd0);
        chk("rst_acc_clr", {31'd0, acc_clr}, 32'd0);
        chk("rst_dump", {31'd0, dump}, 32'd0);
        chk("rst_status", status, 32'h0000_0000);
        user_rst_n = 1'b1;
        idle(2);

        // Run 1: n=2, ndumps=3, 8 samples per frame
        cfg_log2_navg = 5'd2;
        cfg_ndumps    = 16'd3;
        ctrl_start    = 1'b1;
        cyc();
        dump_total = 0;
        for (int k = 1; k <= 13; k++) begin
            frame((k == 13) ? 1 : 8, 1'b1, d, c, e);
            chk($sformatf("r1_dump_sof%0d", k), {31'd0, d},
                {31'd0, (k == 5 || k == 9 || k == 13)});
            chk($sformatf("r1_clr_sof%0d", k), {31'd0, c},
                {31'd0, (k == 1 || k == 5 || k == 9)});
        end
        chk("r1_en_last_sof", {31'd0, e}, 32'd0);
        idle(2);
        chk("r1_dump_total", dump_total, 32'd3);
        chk("r1_status_done", status, 32'h4C00_0003);
        // ctrl_start still high in DONE: traffic must not restart anything
        frame(4, 1'b1, d, c, e);
        chk("r1_done_hold_en", {31'd0, e}, 32'd0);
        idle(2);
        chk("r1_done_hold_status", status, 32'h4C00_0003);
        ctrl_start = 1'b0;
        idle(2);
        chk("r1_idle_status", status, 32'h0000_0003);

        // Run 2: n=0, continuous, 20 frames
        cfg_log2_navg = 5'd0;
        cfg_ndumps    = 16'd0;
        ctrl_start    = 1'b1;
        cyc();
        dump_total = 0;
        for (int k = 1; k <= 20; k++) frame(3, 1'b1, d, c, e);
        idle(2);
        chk("r2_dump_total", dump_total, 32'd19);
        chk("r2_status_busy", status, 32'h8800_0013);
        // Second start edge while busy is ignored
        ctrl_start = 1'b0;
        cyc();
        ctrl_start = 1'b1;
        idle(3);
        chk("r2_reedge_status", status, 32'h8800_0013);
        // Abort coinciding with a completing SOF
        ctrl_abort   = 1'b1;
        sample_valid = 1'b1;
        frame_sof    = 1'b1;
        cyc();
        chk("r2_abort_dump", {31'd0, dump}, 32'd0);
        chk("r2_abort_en", {31'd0, acc_en}, 32'd0);
        ctrl_abort = 1'b0;
        frame(3, 1'b1, d, c, e);
        chk("r2_after_abort_en", {31'd0, e}, 32'd0);
        chk("r2_after_abort_dump", {31'd0, d}, 32'd0);
        idle(1);
        chk("r2_abort_status", status, 32'h0000_0013);
        ctrl_start = 1'b0;
        idle(2);

        // Run 3: n=1, ndumps=3, snapshot buffer busy on the 2nd dump
        cfg_log2_navg = 5'd1;
        cfg_ndumps    = 16'd3;
        ctrl_start    = 1'b1;
        cyc();
        for (int k = 1; k <= 7; k++) begin
            frame((k == 7) ? 1 : 4, (k != 5), d, c, e);
            if (k == 5) chk("r3_dump_while_busy", {31'd0, d}, 32'd1);
            if (k == 6) chk("r3_ovf_mid_run", {31'd0, status[29]}, 32'd1);
        end
        idle(2);
        chk("r3_status_ovf_done", status, 32'h6C00_0003);
        ctrl_start = 1'b0;
        idle(2);
        chk("r3_ovf_kept_idle", status, 32'h2000_0003);
        // Re-arm; clamp of large n (31 -> 10) is latched here
        cfg_log2_navg = 5'd31;
        ctrl_start    = 1'b1;
        idle(3);
        chk("r4_rearm_status", status, 32'h8400_0000);

        // Samples before the first SOF are ignored
        sample_valid = 1'b1;
        frame_sof    = 1'b0;
        cyc();
        chk("r4_pre_sof_en", {31'd0, acc_en}, 32'd0);
        frame(4, 1'b1, d, c, e);
        chk("r4_first_sof_clr", {31'd0, c}, 32'd1);
        chk("r4_first_sof_en", {31'd0, e}, 32'd1);
        // With n clamped to 10, a second SOF only increments
        frame(2, 1'b1, d, c, e);
        chk("r4_clamped_no_dump", {31'd0, d}, 32'd0);
        chk("r4_clamped_no_clr", {31'd0, c}, 32'd0);
        sample_valid = 1'b1;
        frame_sof    = 1'b0;
        cyc();
        chk("r4_mid_accum_en", {31'd0, acc_en}, 32'd1);

        // Asynchronous reset off the clock edge, mid-ACCUM
        #3;
        user_rst_n = 1'b0;
        ctrl_start = 1'b0;
        #1;
        chk("rst_async_en", {31'd0, acc_en}, 32'd0);
        chk("rst_async_status", status, 32'h0000_0000);
        #1;
        user_rst_n = 1'b1;
        base = dump_total;
        for (int k = 0; k < 3; k++) frame(2, 1'b1, d, c, e);
        idle(2);
        chk("rst_no_dump_after", dump_total, base);
        chk("rst_idle_status", status, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
